// File: rtl/ds_pwm_output_stage.sv
// Edge-aligned PWM renderer for quantised delta-sigma samples.
// Pending/active double buffer, paced by sample_req, with sticky overrun/underrun flags.
module ds_pwm_output_stage #(
    parameter int unsigned OUT_BITS = 9,
    parameter int unsigned REQ_LEAD = 16,
    parameter bit          INVERT   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [OUT_BITS-1:0] y,
    input  logic                y_valid,
    input  logic                clear_flags,
    output logic                pwm_out,
    output logic                sample_req,
    output logic                period_start,
    output logic                overrun,
    output logic                underrun
);

    localparam int unsigned          PERIOD   = 32'(1) << OUT_BITS;
    localparam logic [OUT_BITS-1:0]  CNT_MAX  = OUT_BITS'(PERIOD - 1);
    localparam logic [OUT_BITS-1:0]  REQ_CNT  = OUT_BITS'(PERIOD - 1 - REQ_LEAD);
    localparam logic [OUT_BITS-1:0]  MIDSCALE = {1'b1, (OUT_BITS-1)'(0)};

    logic [OUT_BITS-1:0] cnt;
    logic [OUT_BITS-1:0] d_active;
    logic [OUT_BITS-1:0] d_pending;
    logic                pending_full;
    logic                pwm_q;

    logic                wrap_c;
    logic [OUT_BITS-1:0] d_in_c;
    logic                ovr_set_c;
    logic                udr_set_c;

    // Offset-binary conversion: flipping the sign bit maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1.
    assign d_in_c = {~y[OUT_BITS-1], y[OUT_BITS-2:0]};
    assign wrap_c = en && (cnt == CNT_MAX);

    // Flag set events; a wrap always drains or bypasses, so a write at wrap is never an overrun.
    always_comb begin
        ovr_set_c = 1'b0;
        udr_set_c = 1'b0;
        if (wrap_c) begin
            udr_set_c = !pending_full && !y_valid;
        end else begin
            ovr_set_c = y_valid && pending_full;
        end
    end

    // Counter and PWM compare; pwm_q holds while en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            pwm_q        <= 1'b0;
            period_start <= 1'b0;
            sample_req   <= 1'b0;
        end else begin
            period_start <= en && (cnt == '0);
            sample_req   <= en && (cnt == REQ_CNT);
            if (en) begin
                cnt   <= cnt + OUT_BITS'(1);
                pwm_q <= (cnt < d_active);
            end
        end
    end

    // Pending/active double buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_active     <= MIDSCALE;
            d_pending    <= '0;
            pending_full <= 1'b0;
        end else if (wrap_c) begin
            if (pending_full) begin
                d_active <= d_pending;
                if (y_valid) begin
                    d_pending <= d_in_c;
                end else begin
                    pending_full <= 1'b0;
                end
            end else if (y_valid) begin
                d_active <= d_in_c;
            end
        end else if (y_valid) begin
            d_pending    <= d_in_c;
            pending_full <= 1'b1;
        end
    end

    // Sticky flags; a set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= (overrun  && !clear_flags) || ovr_set_c;
            underrun <= (underrun && !clear_flags) || udr_set_c;
        end
    end

    assign pwm_out = pwm_q ^ INVERT;

endmodule

// File: tb/tb_ds_pwm_output_stage.sv
// Directed bench for ds_pwm_output_stage at OUT_BITS=9, REQ_LEAD=16, INVERT=0.
module tb_ds_pwm_output_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [8:0] y;
    logic       y_valid;
    logic       clear_flags;
    logic       pwm_out;
    logic       sample_req;
    logic       period_start;
    logic       overrun;
    logic       underrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Auto-responder: answers sample_req with resp_y after resp_delay cycles.
    bit         resp_on    = 1'b0;
    logic [8:0] resp_y     = '0;
    int         resp_delay = 3;
    int         resp_timer = 0;

    always #5 clk = ~clk;

    ds_pwm_output_stage #(.OUT_BITS(9), .REQ_LEAD(16), .INVERT(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .y            (y),
        .y_valid      (y_valid),
        .clear_flags  (clear_flags),
        .pwm_out      (pwm_out),
        .sample_req   (sample_req),
        .period_start (period_start),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        y_valid     = 1'b0;
        clear_flags = 1'b0;
        if (resp_on) begin
            if (resp_timer > 0) begin
                resp_timer--;
                if (resp_timer == 0) begin
                    y_valid = 1'b1;
                    y       = resp_y;
                end
            end
            if (sample_req) resp_timer = resp_delay;
        end else begin
            resp_timer = 0;
        end
    endtask

    // One full enabled period starting at cnt==0, with optional injections.
    task automatic run_period(input string name, input int exp_high,
                              input int ia, input logic [8:0] ya,
                              input int ib, input logic [8:0] yb, input int clr_i);
        int highs = 0;
        int reqs  = 0;
        en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (i == ia) begin y_valid = 1'b1; y = ya; end
            if (i == ib) begin y_valid = 1'b1; y = yb; end
            if (i == clr_i) clear_flags = 1'b1;
            tick();
            if (pwm_out) highs++;
            if (sample_req) reqs++;
            if (i == 0) begin
                n_tests++;
                if (period_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_period_start: got %b expected 1", name, period_start);
                end
            end
            if (i == 495) begin
                n_tests++;
                if (sample_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_sample_req_at_495: got %b expected 1", name, sample_req);
                end
            end
        end
        n_tests++;
        if (highs !== exp_high) begin
            n_fail++;
            $display("FAIL %s_duty: got %0d high cycles expected %0d", name, highs, exp_high);
        end
        n_tests++;
        if (reqs !== 1) begin
            n_fail++;
            $display("FAIL %s_req_count: got %0d expected 1", name, reqs);
        end
    endtask

    task automatic clear_all_flags();
        en          = 1'b0;
        clear_flags = 1'b1;
        tick();
        en = 1'b1;
        n_tests++;
        if ({overrun, underrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_flags: got %b expected 00", {overrun, underrun});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; y = '0; y_valid = 1'b0; clear_flags = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if ({pwm_out, sample_req, period_start, overrun, underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {pwm_out, sample_req, period_start, overrun, underrun});
        end
    endtask

    task automatic test_midscale();
        int highs = 0;
        en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (pwm_out) highs++;
            if (i == 510) begin
                n_tests++;
                if (underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midscale_underrun_early: got %b expected 0", underrun);
                end
            end
        end
        n_tests++;
        if (highs !== 256) begin
            n_fail++;
            $display("FAIL midscale_duty: got %0d expected 256", highs);
        end
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL midscale_underrun_after_wrap: got %b expected 1", underrun);
        end
        clear_all_flags();
    endtask

    task automatic test_duty_extremes();
        resp_on = 1'b1; resp_delay = 3;
        resp_y = 9'h0FF;
        run_period("ext_mid", 256, -1, '0, -1, '0, -1);
        resp_y = 9'h100;
        run_period("ext_max", 511, -1, '0, -1, '0, -1);
        resp_on = 1'b0;
        run_period("ext_zero", 0, -1, '0, -1, '0, -1);
        clear_all_flags();
    endtask

    task automatic test_pacing();
        logic [8:0] ys [8];
        int         exp_d [8];
        ys = '{9'h000, 9'h064, 9'h19C, 9'h0FF, 9'h100, 9'h001, 9'h1FF, 9'h080};
        exp_d = '{0, 256, 356, 156, 511, 0, 257, 255};
        resp_on = 1'b1; resp_delay = 3;
        for (int p = 0; p < 8; p++) begin
            resp_y = ys[p];
            run_period($sformatf("pace%0d", p), exp_d[p], -1, '0, -1, '0, -1);
        end
        resp_on = 1'b0;
        n_tests++;
        if ({overrun, underrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL pacing_flags: got %b expected 00", {overrun, underrun});
        end
    endtask

    task automatic test_overrun();
        run_period("ovr", 384, 100, 9'd10, 200, 9'h1EC, -1);
        n_tests++;
        if ({overrun, underrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL overrun_flags: got %b expected 10", {overrun, underrun});
        end
        run_period("ovr_next", 236, -1, '0, -1, '0, -1);
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_underrun: got %b expected 1", underrun);
        end
        clear_all_flags();
    endtask

    task automatic test_bypass();
        run_period("byp_pre", 236, 511, 9'h040, -1, '0, -1);
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_underrun: got %b expected 0", underrun);
        end
        run_period("byp", 320, -1, '0, -1, '0, 511);
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear: got %b expected 1", underrun);
        end
    endtask

    task automatic test_freeze_and_reset();
        int highs   = 0;
        int frz_bad = 0;
        en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (i == 310) begin
                en = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    if (k == 20) begin y_valid = 1'b1; y = 9'h0C0; end
                    if (k == 50) clear_flags = 1'b1;
                    tick();
                    if (pwm_out !== 1'b1 || sample_req !== 1'b0 || period_start !== 1'b0) frz_bad++;
                end
                n_tests++;
                if (frz_bad !== 0) begin
                    n_fail++;
                    $display("FAIL freeze_outputs: got %0d bad cycles expected 0", frz_bad);
                end
                n_tests++;
                if (underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL freeze_clear: got %b expected 0", underrun);
                end
                en = 1'b1;
            end
            tick();
            if (pwm_out) highs++;
        end
        n_tests++;
        if (highs !== 320) begin
            n_fail++;
            $display("FAIL freeze_duty: got %0d expected 320", highs);
        end
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 50 || i == 60) begin y_valid = 1'b1; y = 9'h1C0; end
            tick();
            if (pwm_out) highs++;
            if (i == 0) begin
                n_tests++;
                if (period_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stretched_period_start: got %b expected 1", period_start);
                end
            end
        end
        n_tests++;
        if (highs !== 300 || overrun !== 1'b1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: got highs=%0d ovr=%b udr=%b expected highs=300 ovr=1 udr=0",
                     highs, overrun, underrun);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({pwm_out, sample_req, period_start, overrun, underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b expected 00000",
                     {pwm_out, sample_req, period_start, overrun, underrun});
        end
        run_period("post_rst1", 256, -1, '0, -1, '0, -1);
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_discards_pending: got underrun=%b expected 1", underrun);
        end
        run_period("post_rst2", 256, -1, '0, -1, '0, -1);
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_duty_extremes();
        test_pacing();
        test_overrun();
        test_bypass();
        test_freeze_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
